// File: rtl/tomasulo_pkg.sv
// Shared types and widths for the Tomasulo memory pipeline.
package tomasulo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TAG_W  = 3;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_RESULT = 2'd2
  } lsb_state_e;

endpackage

// File: rtl/lsb_entry.sv
// One load/store buffer slot: holds the op fields and snoops the CDB for a
// pending store operand.
module lsb_entry
  import tomasulo_pkg::*;
#(
  parameter int unsigned TAG_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic              wr_op_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_data_rdy_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [TAG_W-1:0]  wr_data_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              op_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              data_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  data_tag_o
);

  logic              op_q;
  logic [TAG_W-1:0]  tag_q;
  logic [ADDR_W-1:0] addr_q;
  logic              data_rdy_q;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  data_tag_q;
  logic              new_hit;
  logic              held_hit;

  // A producer broadcasting in the enqueue cycle must not be missed.
  assign new_hit  = (wr_op_i == OP_STORE) && !wr_data_rdy_i && cdb_valid_i &&
                    (cdb_tag_i == wr_data_tag_i);
  assign held_hit = (op_q == OP_STORE) && !data_rdy_q && cdb_valid_i &&
                    (cdb_tag_i == data_tag_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OP_LOAD;
      tag_q      <= '0;
      addr_q     <= '0;
      data_rdy_q <= 1'b0;
      data_q     <= '0;
      data_tag_q <= '0;
    end else if (wr_en_i) begin
      op_q       <= wr_op_i;
      tag_q      <= wr_tag_i;
      addr_q     <= wr_addr_i;
      data_tag_q <= wr_data_tag_i;
      data_rdy_q <= wr_data_rdy_i || new_hit;
      data_q     <= new_hit ? cdb_data_i : wr_data_i;
    end else if (held_hit) begin
      data_rdy_q <= 1'b1;
      data_q     <= cdb_data_i;
    end
  end

  assign op_o       = op_q;
  assign tag_o      = tag_q;
  assign addr_o     = addr_q;
  assign data_rdy_o = data_rdy_q;
  assign data_o     = data_q;
  assign data_tag_o = data_tag_q;

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store buffer: FIFO of memory ops, head-only memory access,
// loads returned over the CDB with a valid/ready handshake.
module load_store_buffer
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_op,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              issue_data_rdy,
  input  logic [DATA_W-1:0] issue_data,
  input  logic [TAG_W-1:0]  issue_data_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              ld_valid,
  output logic [TAG_W-1:0]  ld_tag,
  output logic [DATA_W-1:0] ld_data,
  input  logic              ld_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  lsb_state_e       state_q;
  logic             mem_write_q;
  logic             ld_valid_q;
  logic [TAG_W-1:0] ld_tag_q;
  logic [DATA_W-1:0] ld_data_q;

  logic              e_op     [DEPTH];
  logic [TAG_W-1:0]  e_tag    [DEPTH];
  logic [ADDR_W-1:0] e_addr   [DEPTH];
  logic              e_rdy    [DEPTH];
  logic [DATA_W-1:0] e_data   [DEPTH];
  logic [TAG_W-1:0]  e_dtag   [DEPTH];

  logic              push;
  logic              pop;
  logic              head_valid;
  logic              head_op;
  logic              head_store_rdy;

  assign issue_ready = (count_q < FULL);
  assign push        = issue_valid && issue_ready;
  assign pop         = (state_q == ST_WRITE) || ((state_q == ST_RESULT) && ld_ready);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lsb_entry #(.TAG_W(TAG_W)) u_entry (
      .clk_i         (clock),
      .rst_ni        (resetn),
      .wr_en_i       (push && (wr_ptr_q == PTR_W'(i))),
      .wr_op_i       (issue_op),
      .wr_tag_i      (issue_tag),
      .wr_addr_i     (issue_addr),
      .wr_data_rdy_i (issue_data_rdy),
      .wr_data_i     (issue_data),
      .wr_data_tag_i (issue_data_tag),
      .cdb_valid_i   (cdb_valid),
      .cdb_tag_i     (cdb_tag),
      .cdb_data_i    (cdb_data),
      .op_o          (e_op[i]),
      .tag_o         (e_tag[i]),
      .addr_o        (e_addr[i]),
      .data_rdy_o    (e_rdy[i]),
      .data_o        (e_data[i]),
      .data_tag_o    (e_dtag[i])
    );
  end

  assign head_valid = (count_q != '0);
  assign head_op    = e_op[rd_ptr_q];
  // Head store fires on the same edge its operand is captured from the CDB;
  // the entry holds that value by the time WRITE drives mem_datain.
  assign head_store_rdy = e_rdy[rd_ptr_q] ||
                          (cdb_valid && (cdb_tag == e_dtag[rd_ptr_q]));

  assign mem_addr   = e_addr[rd_ptr_q];
  assign mem_datain = (head_valid && (head_op == OP_STORE)) ? e_data[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      mem_write_q <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_tag_q    <= '0;
      ld_data_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (head_valid) begin
            if (head_op == OP_LOAD) begin
              ld_data_q  <= mem_dataout;
              ld_tag_q   <= e_tag[rd_ptr_q];
              ld_valid_q <= 1'b1;
              state_q    <= ST_RESULT;
            end else if (head_store_rdy) begin
              mem_write_q <= 1'b1;
              state_q     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          mem_write_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        ST_RESULT: begin
          if (ld_ready) begin
            ld_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          mem_write_q <= 1'b0;
          ld_valid_q  <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_write = mem_write_q;
  assign ld_valid  = ld_valid_q;
  assign ld_tag    = ld_tag_q;
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Scoreboard bench for load_store_buffer with a behavioural data memory.
module tb_load_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 3;

  logic              clock;
  logic              resetn;
  logic              issue_valid;
  logic              issue_ready;
  logic              issue_op;
  logic [TAG_W-1:0]  issue_tag;
  logic [3:0]        issue_addr;
  logic              issue_data_rdy;
  logic [15:0]       issue_data;
  logic [TAG_W-1:0]  issue_data_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [15:0]       cdb_data;
  logic [3:0]        mem_addr;
  logic              mem_write;
  logic [15:0]       mem_datain;
  logic [15:0]       mem_dataout;
  logic              ld_valid;
  logic [TAG_W-1:0]  ld_tag;
  logic [15:0]       ld_data;
  logic              ld_ready;

  load_store_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_op       (issue_op),
    .issue_tag      (issue_tag),
    .issue_addr     (issue_addr),
    .issue_data_rdy (issue_data_rdy),
    .issue_data     (issue_data),
    .issue_data_tag (issue_data_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .mem_addr       (mem_addr),
    .mem_write      (mem_write),
    .mem_datain     (mem_datain),
    .mem_dataout    (mem_dataout),
    .ld_valid       (ld_valid),
    .ld_tag         (ld_tag),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready)
  );

  always begin
    clock = 1'b0; #5;
    clock = 1'b1; #5;
  end

  logic        pre_en;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [16];

  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_datain;
  end
  assign mem_dataout = mem[mem_addr];

  typedef struct {
    logic             op;
    logic [TAG_W-1:0] tag;
    logic [3:0]       addr;
    logic             rdy;
    logic [15:0]      val;
    logic [TAG_W-1:0] dtag;
  } op_t;

  int checks = 0;
  int errors = 0;
  logic [15:0]       ref_mem [16];
  logic [TAG_W+15:0] exp_ld [$];
  logic [19:0]       exp_wr [$];

  task automatic drive_op(input op_t o, input bit track);
    issue_valid    = 1'b1;
    issue_op       = o.op;
    issue_tag      = o.tag;
    issue_addr     = o.addr;
    issue_data_rdy = o.rdy;
    issue_data     = o.rdy ? o.val : 16'hDEAD;
    issue_data_tag = o.dtag;
    if (track) begin
      if (o.op) begin
        exp_wr.push_back({o.addr, o.val});
        ref_mem[o.addr] = o.val;
      end else begin
        exp_ld.push_back({o.tag, ref_mem[o.addr]});
      end
    end
  endtask

  task automatic issue(input logic op, input logic [TAG_W-1:0] tag, input logic [3:0] addr,
                       input logic rdy, input logic [15:0] val, input logic [TAG_W-1:0] dtag,
                       input bit track);
    op_t o;
    o = '{op, tag, addr, rdy, val, dtag};
    drive_op(o, track);
    @(negedge clock);
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; issue_valid = 1'b0; issue_op = 1'b0; issue_tag = '0; issue_addr = '0;
    issue_data_rdy = 1'b0; issue_data = '0; issue_data_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; ld_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = (a == 1) ? 16'h0003 : {4{4'(a)}};
      pre_en = 1'b1; pre_addr = 4'(a); pre_data = ref_mem[a];
      @(negedge clock);
    end
    pre_en = 1'b0;
    checks++;
    if (mem_write !== 1'b0 || ld_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: mem_write=%b ld_valid=%b expected 0 0", mem_write, ld_valid);
    end
    checks++;
    if (ld_tag !== '0 || ld_data !== '0) begin
      errors++; $display("FAIL reset_ld: tag=%0d data=%h expected 0 0000", ld_tag, ld_data);
    end
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", issue_ready);
    end
  endtask

  task automatic test_load();
    logic [TAG_W+15:0] e;
    issue(1'b0, 3'd2, 4'd1, 1'b0, '0, '0, 1'b1);
    checks++;
    if (ld_valid !== 1'b0) begin
      errors++; $display("FAIL load_early: ld_valid=%b expected 0 in cycle 1", ld_valid);
    end
    for (int c = 2; c <= 10 && exp_ld.size() != 0; c++) begin
      @(negedge clock);
      if (ld_valid && ld_ready) begin
        e = exp_ld.pop_front();
        checks++;
        if ({ld_tag, ld_data} !== e) begin
          errors++; $display("FAIL load_result: tag=%0d data=%h expected tag=%0d data=%h",
                             ld_tag, ld_data, e[TAG_W+15:16], e[15:0]);
        end
        checks++;
        if (c != 2) begin
          errors++; $display("FAIL load_latency: got cycle %0d expected 2", c);
        end
      end
    end
    checks++;
    if (exp_ld.size() != 0) begin
      errors++; $display("FAIL load_timeout: %0d results pending expected 0", exp_ld.size());
      exp_ld.delete();
    end
    @(negedge clock);
    checks++;
    if (ld_valid !== 1'b0) begin
      errors++; $display("FAIL load_pop: ld_valid=%b expected 0 after grant", ld_valid);
    end
  endtask

  task automatic test_store();
    logic [19:0]       w;
    logic [TAG_W+15:0] e;
    issue(1'b1, '0, 4'd5, 1'b1, 16'h00AA, '0, 1'b1);
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL store_early: mem_write=%b expected 0", mem_write);
    end
    @(negedge clock);
    w = exp_wr.pop_front();
    checks++;
    if (mem_write !== 1'b1 || {mem_addr, mem_datain} !== w) begin
      errors++; $display("FAIL store_write: we=%b addr=%h data=%h expected 1 %h %h",
                         mem_write, mem_addr, mem_datain, w[19:16], w[15:0]);
    end
    @(negedge clock);
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL store_one_cycle: mem_write=%b expected 0", mem_write);
    end
    issue(1'b0, 3'd6, 4'd5, 1'b0, '0, '0, 1'b1);
    for (int c = 0; c < 8 && exp_ld.size() != 0; c++) begin
      @(negedge clock);
      if (ld_valid && ld_ready) begin
        e = exp_ld.pop_front();
        checks++;
        if ({ld_tag, ld_data} !== e) begin
          errors++; $display("FAIL store_readback: tag=%0d data=%h expected tag=%0d data=%h",
                             ld_tag, ld_data, e[TAG_W+15:16], e[15:0]);
        end
      end
    end
    checks++;
    if (exp_ld.size() != 0) begin
      errors++; $display("FAIL store_readback_timeout: %0d pending expected 0", exp_ld.size());
      exp_ld.delete();
    end
  endtask

  task automatic test_cdb();
    logic [19:0]       w;
    logic [TAG_W+15:0] e;
    issue(1'b1, '0, 4'd7, 1'b0, 16'h1234, 3'd4, 1'b1);
    issue(1'b0, 3'd1, 4'd7, 1'b0, '0, '0, 1'b1);
    checks++;
    if (mem_write !== 1'b0 || ld_valid !== 1'b0) begin
      errors++; $display("FAIL cdb_blocked: we=%b ld_valid=%b expected 0 0", mem_write, ld_valid);
    end
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'hFFFF;
    @(negedge clock);
    cdb_valid = 1'b0;
    checks++;
    if (mem_write !== 1'b0 || ld_valid !== 1'b0) begin
      errors++; $display("FAIL cdb_wrong_tag: we=%b ld_valid=%b expected 0 0", mem_write, ld_valid);
    end
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h1234;
    @(negedge clock);
    cdb_valid = 1'b0;
    w = exp_wr.pop_front();
    checks++;
    if (mem_write !== 1'b1 || {mem_addr, mem_datain} !== w || ld_valid !== 1'b0) begin
      errors++; $display("FAIL cdb_write: we=%b addr=%h data=%h ldv=%b expected 1 %h %h 0",
                         mem_write, mem_addr, mem_datain, ld_valid, w[19:16], w[15:0]);
    end
    for (int c = 0; c < 8 && exp_ld.size() != 0; c++) begin
      @(negedge clock);
      if (ld_valid && ld_ready) begin
        e = exp_ld.pop_front();
        checks++;
        if ({ld_tag, ld_data} !== e) begin
          errors++; $display("FAIL cdb_load: tag=%0d data=%h expected tag=%0d data=%h",
                             ld_tag, ld_data, e[TAG_W+15:16], e[15:0]);
        end
      end
    end
    checks++;
    if (exp_ld.size() != 0) begin
      errors++; $display("FAIL cdb_load_timeout: %0d pending expected 0", exp_ld.size());
      exp_ld.delete();
    end
  endtask

  task automatic test_full();
    logic [19:0]       w;
    logic [TAG_W+15:0] e;
    bit                extra;
    issue(1'b1, '0, 4'd2, 1'b0, 16'h0055, 3'd5, 1'b1);
    for (int t = 0; t < 3; t++) issue(1'b0, 3'(t), 4'd2, 1'b0, '0, '0, 1'b1);
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected 0", issue_ready);
    end
    issue_valid = 1'b1; issue_op = 1'b0; issue_tag = 3'd7; issue_addr = 4'd3;
    @(negedge clock);
    @(negedge clock);
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0055;
    @(negedge clock);
    cdb_valid = 1'b0;
    w = exp_wr.pop_front();
    checks++;
    if (mem_write !== 1'b1 || {mem_addr, mem_datain} !== w) begin
      errors++; $display("FAIL full_write: we=%b addr=%h data=%h expected 1 %h %h",
                         mem_write, mem_addr, mem_datain, w[19:16], w[15:0]);
    end
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_pop: got %b expected 0 before pop edge", issue_ready);
    end
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL full_restore: got %b expected 1", issue_ready);
    end
    for (int c = 0; c < 14 && exp_ld.size() != 0; c++) begin
      if (ld_valid && ld_ready) begin
        e = exp_ld.pop_front();
        checks++;
        if ({ld_tag, ld_data} !== e) begin
          errors++; $display("FAIL full_load: tag=%0d data=%h expected tag=%0d data=%h",
                             ld_tag, ld_data, e[TAG_W+15:16], e[15:0]);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (exp_ld.size() != 0) begin
      errors++; $display("FAIL full_timeout: %0d pending expected 0", exp_ld.size());
      exp_ld.delete();
    end
    extra = 1'b0;
    for (int c = 0; c < 5; c++) begin
      extra |= ld_valid;
      @(negedge clock);
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++; $display("FAIL full_ignored: extra load result seen=%b expected 0", extra);
    end
  endtask

  task automatic test_stall();
    logic [TAG_W+15:0] e;
    ld_ready = 1'b0;
    issue(1'b0, 3'd3, 4'd5, 1'b0, '0, '0, 1'b1);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = 4'd5; pre_data = 16'hFFFF;
    ref_mem[5] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ld_valid !== 1'b1 || {ld_tag, ld_data} !== exp_ld[0]) begin
        errors++; $display("FAIL stall_hold: v=%b tag=%0d data=%h in stall cycle %0d expected held value",
                           ld_valid, ld_tag, ld_data, k);
      end
      @(negedge clock);
      pre_en = 1'b0;
    end
    ld_ready = 1'b1;
    e = exp_ld.pop_front();
    checks++;
    if (ld_valid !== 1'b1 || {ld_tag, ld_data} !== e) begin
      errors++; $display("FAIL stall_grant: v=%b tag=%0d data=%h expected 1 %0d %h",
                         ld_valid, ld_tag, ld_data, e[TAG_W+15:16], e[15:0]);
    end
    @(negedge clock);
    checks++;
    if (ld_valid !== 1'b0) begin
      errors++; $display("FAIL stall_pop: ld_valid=%b expected 0", ld_valid);
    end
  endtask

  task automatic test_back_to_back();
    op_t               prog [$];
    logic [19:0]       w;
    logic [TAG_W+15:0] e;
    int                idx;
    prog.push_back('{1'b1, 3'd0, 4'd3, 1'b1, 16'h1111, 3'd0});
    prog.push_back('{1'b0, 3'd1, 4'd3, 1'b0, 16'h0000, 3'd0});
    prog.push_back('{1'b1, 3'd0, 4'd3, 1'b0, 16'h2222, 3'd6});
    prog.push_back('{1'b0, 3'd2, 4'd3, 1'b0, 16'h0000, 3'd0});
    prog.push_back('{1'b0, 3'd3, 4'd1, 1'b0, 16'h0000, 3'd0});
    prog.push_back('{1'b1, 3'd0, 4'd4, 1'b1, 16'h4444, 3'd0});
    prog.push_back('{1'b0, 3'd5, 4'd4, 1'b0, 16'h0000, 3'd0});
    idx = 0;
    for (int c = 0; c < 60 && (idx < prog.size() || exp_ld.size() != 0 || exp_wr.size() != 0); c++) begin
      if (mem_write) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++; $display("FAIL b2b_write: unexpected write addr=%h data=%h expected none", mem_addr, mem_datain);
        end else begin
          w = exp_wr.pop_front();
          if ({mem_addr, mem_datain} !== w) begin
            errors++; $display("FAIL b2b_write: addr=%h data=%h expected %h %h",
                               mem_addr, mem_datain, w[19:16], w[15:0]);
          end
        end
      end
      if (ld_valid && ld_ready) begin
        checks++;
        if (exp_ld.size() == 0) begin
          errors++; $display("FAIL b2b_load: unexpected tag=%0d data=%h expected none", ld_tag, ld_data);
        end else begin
          e = exp_ld.pop_front();
          if ({ld_tag, ld_data} !== e) begin
            errors++; $display("FAIL b2b_load: tag=%0d data=%h expected tag=%0d data=%h",
                               ld_tag, ld_data, e[TAG_W+15:16], e[15:0]);
          end
        end
      end
      issue_valid = 1'b0;
      cdb_valid   = 1'b0;
      if (idx < prog.size() && issue_ready) begin
        drive_op(prog[idx], 1'b1);
        if (!prog[idx].op || !prog[idx].rdy) begin
          if (prog[idx].op) begin
            cdb_valid = 1'b1; cdb_tag = prog[idx].dtag; cdb_data = prog[idx].val;
          end
        end
        idx++;
      end
      @(negedge clock);
    end
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    checks++;
    if (exp_ld.size() != 0 || exp_wr.size() != 0 || idx != prog.size()) begin
      errors++; $display("FAIL b2b_timeout: ld=%0d wr=%0d issued=%0d expected 0 0 %0d",
                         exp_ld.size(), exp_wr.size(), idx, prog.size());
      exp_ld.delete(); exp_wr.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [TAG_W+15:0] e;
    bit                seen;
    issue(1'b1, '0, 4'd9, 1'b1, 16'hBEEF, '0, 1'b0);
    issue(1'b0, 3'd4, 4'd1, 1'b0, '0, '0, 1'b0);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup: mem_write=%b expected 1", mem_write);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || ld_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_clear: we=%b ldv=%b ready=%b expected 0 0 1",
                         mem_write, ld_valid, issue_ready);
    end
    @(negedge clock);
    resetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seen |= (mem_write | ld_valid);
      @(negedge clock);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_mid_discard: activity=%b expected 0", seen);
    end
    issue(1'b0, 3'd5, 4'd9, 1'b0, '0, '0, 1'b1);
    @(negedge clock);
    e = exp_ld.pop_front();
    checks++;
    if (ld_valid !== 1'b1 || {ld_tag, ld_data} !== e) begin
      errors++; $display("FAIL rst_mid_nowrite: v=%b tag=%0d data=%h expected 1 %0d %h",
                         ld_valid, ld_tag, ld_data, e[TAG_W+15:16], e[15:0]);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_cdb();
    test_full();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_buffer.md
LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

Interface
REQ-001 SHALL: parameter DEPTH, default 4, number of queue entries (power of two).
REQ-002 SHALL: parameter TAG_W, default 3, width of reservation-station tags.
REQ-003 SHALL: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL: resetn  input  1  asynchronous reset, active-low.
REQ-005 SHALL: issue_valid  input  1  issue stage offers a memory op.
REQ-006 SHALL: issue_ready  output  1  buffer accepts the op this cycle.
REQ-007 SHALL: issue_op  input  1  0 = load, 1 = store.
REQ-008 SHALL: issue_tag  input  TAG_W  destination tag for the load result.
REQ-009 SHALL: issue_addr  input  4  effective data-memory address.
REQ-010 SHALL: issue_data_rdy / issue_data / issue_data_tag  input  1 / 16 / TAG_W  store operand: value if rdy = 1, else producer tag.
REQ-011 SHALL: cdb_valid / cdb_tag / cdb_data  input  1 / TAG_W / 16  common data bus snoop.
REQ-012 SHALL: mem_addr / mem_write / mem_datain  output  4 / 1 / 16  drive data memory.
REQ-013 SHALL: mem_dataout  input  16  data memory combinational read data.
REQ-014 SHALL: ld_valid / ld_tag / ld_data  output  1 / TAG_W / 16  load result request to CDB.
REQ-015 SHALL: ld_ready  input  1  CDB grant; transfer occurs when ld_valid and ld_ready are both 1.

Function
REQ-016 SHALL: hold ops in strict program-order FIFO; only the head entry accesses memory.
REQ-017 SHALL: drive issue_ready = (count < DEPTH), independent of same-cycle pop.
REQ-018 SHALL: enqueue when issue_valid and issue_ready; ignore issue_valid otherwise.
REQ-019 SHALL: each cycle, every store entry with data not ready and tag == cdb_tag while cdb_valid captures cdb_data and sets ready.
REQ-020 SHALL: an entry enqueued with a pending tag matching the same-cycle CDB broadcast is stored as ready with cdb_data.
REQ-021 SHALL: run FSM states IDLE, WRITE, RESULT.
REQ-022 SHALL: in IDLE with a head load, register mem_dataout into ld_data and the head tag into ld_tag, then go to RESULT.
REQ-023 SHALL: in RESULT, hold ld_valid = 1 with stable ld_tag/ld_data; on ld_ready, pop the head and return to IDLE.
REQ-024 SHALL: in IDLE with a head store whose data is ready, go to WRITE.
REQ-025 SHALL: in WRITE, assert registered mem_write for exactly one cycle, pop the head, and return to IDLE.
REQ-026 SHALL: stay in IDLE on an empty queue or a head store with pending data; later entries never bypass it.
REQ-027 SHALL: drive mem_addr from the head entry, and mem_datain from head store data, else 0.
REQ-028 SHALL: keep mem_addr/mem_datain stable throughout WRITE.
REQ-029 SHALL: keep mem_write glitch-free, since memory writes are level-sensitive.
REQ-030 SHALL: load latency = 2 cycles from the accepting edge to ld_valid = 1 with an empty queue.
REQ-031 SHALL: store latency = mem_write high in the 2nd cycle after acceptance.
REQ-032 SHALL: wrap FIFO pointers modulo DEPTH; count stays unchanged on simultaneous push and pop.

Reset
REQ-033 SHALL: on resetn = 0, immediately clear count/pointers, set FSM to IDLE, and set mem_write, ld_valid, ld_tag, ld_data to 0.
REQ-034 SHALL: an in-flight op is discarded on reset mid-operation, with no memory write after resetn falls.
REQ-035 SHALL: after reset release, issue_ready = 1.

Structure
REQ-036 SHALL: shared package tomasulo_pkg holds DATA_W = 16, ADDR_W = 4, TAG_W, the OP_LOAD/OP_STORE encoding and the FSM state enum.
REQ-037 SHALL: one sub-module, lsb_entry, implements the per-entry storage and CDB snoop/capture logic.

Verification
REQ-038 SHALL: with mem[1] = 0x0003, load addr 1 tag 2 and ld_ready = 1 -> ld_valid in cycle 2 with ld_tag = 2, ld_data = 0x0003, popped after 1 cycle.
REQ-039 SHALL: store addr 5 data 0x00AA ready -> mem_write high for exactly 1 cycle, addr 5, datain 0x00AA; a subsequent load addr 5 returns 0x00AA.
REQ-040 SHALL: store pending tag 4, then cdb_valid tag 4 data 0x1234 -> WRITE next cycle with mem_datain = 0x1234; a load queued behind it waits.
REQ-041 SHALL: 4 issues with head blocked -> issue_ready = 0, a 5th issue_valid is ignored, and a pop restores issue_ready = 1.
REQ-042 SHALL: load in RESULT with ld_ready = 0 for 3 cycles -> ld_valid/ld_data held stable, popped on grant.
REQ-043 SHALL: resetn low during WRITE -> mem_write = 0 immediately, queue empty, ld_valid = 0.
